// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule sizes, round constants, FSM state type
// and the 32-bit word type used by the key expansion datapath.
package aes_pkg;

  localparam int NR     = 10;
  localparam int KW     = 128;
  localparam int W_BITS = 1408;

  // Round constants, first byte of each Rcon word; index 1..10.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} keyexp_state_t;

  typedef logic [31:0] aes_word_t;

  // Round constant for a 4-bit round index; out-of-range indices give 0.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (rnd == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational. Also used by SubBytes.
module aes_sbox (
  input  logic [7:0] sbox_i,
  output logic [7:0] sbox_o
);

  // Element 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Table lookup.
  always_comb begin
    sbox_o = SBOX[sbox_i];
  end

endmodule

// File: rtl/key_expansion.sv
// Sequential AES-128 key schedule: one round key per clock, 10 cycles,
// four S-box lookups. Slot r of w is w[1407-128r -: 128]; slot 0 is the key.
// Optional macro KEYEXP_RESTART_EN: a start during EXPAND restarts the
// expansion with the new key instead of being ignored.
module key_expansion
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [KW-1:0]     key_in,
  output logic [W_BITS-1:0] w,
  output logic              busy,
  output logic              done,
  output logic              keys_valid
);

  if (NR != 10 || KW != 128) begin : g_bad_cfg
    $error("key_expansion supports only AES-128 (NR=10, KW=128)");
  end

  keyexp_state_t     state_q;
  logic [3:0]        rnd_q;
  logic [W_BITS-1:0] w_q;
  logic              busy_q;
  logic              done_q;
  logic              kv_q;

  logic [KW-1:0]     prev_key;
  aes_word_t         p0, p1, p2, p3;
  aes_word_t         rot_w, sub_w, t_w;
  logic [KW-1:0]     next_key_d;

  // Select the previously written slot (rnd-1) as the round input.
  always_comb begin
    prev_key = '0;
    for (int s = 0; s < NR; s++) begin
      if (rnd_q == 4'(s + 1)) prev_key = w_q[W_BITS-1-KW*s -: KW];
    end
  end

  assign p0    = prev_key[127:96];
  assign p1    = prev_key[95:64];
  assign p2    = prev_key[63:32];
  assign p3    = prev_key[31:0];
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .sbox_i (rot_w[8*b +: 8]),
      .sbox_o (sub_w[8*b +: 8])
    );
  end

  // Round function: the four next words chain through the previous slot.
  always_comb begin
    t_w        = sub_w ^ {rcon_of(rnd_q), 24'h0};
    next_key_d = '0;
    next_key_d[127:96] = p0 ^ t_w;
    next_key_d[95:64]  = p1 ^ next_key_d[127:96];
    next_key_d[63:32]  = p2 ^ next_key_d[95:64];
    next_key_d[31:0]   = p3 ^ next_key_d[63:32];
  end

  // Control FSM with registered handshake outputs and round-key storage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            w_q[W_BITS-1 -: KW] <= key_in;
            rnd_q   <= 4'd1;
            kv_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        EXPAND: begin
`ifdef KEYEXP_RESTART_EN
          if (start) begin
            w_q[W_BITS-1 -: KW] <= key_in;
            rnd_q   <= 4'd1;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end else
`endif
          if (rnd_q >= 4'd1 && rnd_q <= 4'(NR)) begin
            for (int s = 1; s <= NR; s++) begin
              if (rnd_q == 4'(s)) w_q[W_BITS-1-KW*s -: KW] <= next_key_d;
            end
            if (rnd_q == 4'(NR)) begin
              rnd_q   <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              kv_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end else begin
            // Out-of-range round index is treated as idle.
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          rnd_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign w          = w_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;

endmodule
